// File: rtl/rob_multi_cdb.sv
// Reorder buffer with NCDB result-capture channels, in-order single retire and mispredict flush.
// Optional ROB_CDB_BYPASS_EN: operand lookup also forwards from the CDB channels in the broadcast cycle.
module rob_multi_cdb #(
  parameter int DEPTH = 16,
  parameter int NCDB  = 3,
  parameter int XLEN  = 32,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int TAG_W = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [4:0]            alloc_rd,
  input  logic                  alloc_is_branch,
  output logic                  alloc_ready,
  output logic [TAG_W-1:0]      alloc_tag,
  input  logic [TAG_W-1:0]      q1_tag,
  input  logic [TAG_W-1:0]      q2_tag,
  output logic                  q1_ready,
  output logic                  q2_ready,
  output logic [XLEN-1:0]       q1_data,
  output logic [XLEN-1:0]       q2_data,
  input  logic [NCDB-1:0]       cdb_valid,
  input  logic [NCDB*TAG_W-1:0] cdb_tag,
  input  logic [NCDB*XLEN-1:0]  cdb_data,
  input  logic [NCDB-1:0]       cdb_mispredict,
  output logic                  commit_valid,
  output logic [4:0]            commit_rd,
  output logic [XLEN-1:0]       commit_data,
  output logic [TAG_W-1:0]      commit_tag,
  output logic                  flush,
  output logic [XLEN-1:0]       redirect_pc,
  output logic [IDX_W:0]        count
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d, br_q, br_d, misp_q, misp_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [XLEN-1:0]  data_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             accept, retire;

  // Handshake: an entry is taken only on a cycle with alloc_valid && alloc_ready;
  // a refused request is simply held by dispatch, nothing is queued here.
  assign alloc_ready  = (count_q != FULL_CNT) && !flush;
  assign alloc_tag    = {1'b0, tail_q};
  assign accept       = alloc_valid && alloc_ready;
  assign commit_valid = (count_q != '0) && ready_q[head_q];
  assign retire       = commit_valid;
  assign commit_rd    = br_q[head_q] ? 5'd0 : rd_q[head_q];
  assign commit_data  = data_q[head_q];
  assign commit_tag   = {1'b0, head_q};
  assign flush        = commit_valid && br_q[head_q] && misp_q[head_q];
  assign redirect_pc  = data_q[head_q];
  assign count        = count_q;

  logic [TAG_W-1:0] q_tag [2];
  logic             q_rdy [2];
  logic [XLEN-1:0]  q_dat [2];

  assign q_tag[0] = q1_tag;
  assign q_tag[1] = q2_tag;
  assign q1_ready = q_rdy[0];
  assign q1_data  = q_dat[0];
  assign q2_ready = q_rdy[1];
  assign q2_data  = q_dat[1];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_rdy[p] = 1'b0;
      q_dat[p] = '0;
      if (q_tag[p][TAG_W-1]) begin
        q_rdy[p] = 1'b1;
      end else if (ready_q[q_tag[p][IDX_W-1:0]]) begin
        q_rdy[p] = 1'b1;
        q_dat[p] = data_q[q_tag[p][IDX_W-1:0]];
      end
`ifdef ROB_CDB_BYPASS_EN
      // Walk channels high to low so the lowest matching channel lands last and wins.
      if (!q_tag[p][TAG_W-1]) begin
        for (int k = NCDB-1; k >= 0; k--) begin
          if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == q_tag[p])) begin
            q_rdy[p] = 1'b1;
            q_dat[p] = cdb_data[k*XLEN +: XLEN];
          end
        end
      end
`endif
    end
  end

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    br_d    = br_q;
    misp_d  = misp_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      busy_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int k = NCDB-1; k >= 0; k--) begin
          if (cdb_valid[k] && !cdb_tag[k*TAG_W + TAG_W-1] &&
              (cdb_tag[k*TAG_W +: IDX_W] == IDX_W'(e)) && busy_q[e]) begin
            ready_d[e] = 1'b1;
            data_d[e]  = cdb_data[k*XLEN +: XLEN];
            misp_d[e]  = cdb_mispredict[k];
          end
        end
      end
      if (retire) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + IDX_W'(1);
      end
      // The tail slot is never busy when accept is high, so it cannot collide with a capture.
      if (accept) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        misp_d[tail_q]  = 1'b0;
        br_d[tail_q]    = alloc_is_branch;
        rd_d[tail_q]    = alloc_rd;
        tail_d          = tail_q + IDX_W'(1);
      end
      count_d = count_q + (IDX_W+1)'(accept) - (IDX_W+1)'(retire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      ready_q <= '0;
      br_q    <= '0;
      misp_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        rd_q[e]   <= '0;
        data_q[e] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      br_q    <= br_d;
      misp_q  <= misp_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: doc/rob_multi_cdb.md
# rob_multi_cdb

Parametrised reorder buffer for the out-of-order core. It sits between the decoder/dispatch stage, the NCDB common data bus channels (ALU, branch, load/store) and the register file. It allocates one entry per dispatched instruction and captures results from every CDB channel in the same cycle. It retires in program order, one entry per cycle, and flushes all speculative state when a mispredicted branch reaches the head.

## Interface
- DEPTH, 16: entry count; power of two, ≥ 4
- NCDB, 3: number of CDB channels
- XLEN, 32: data width
- IDX_W, $clog2(DEPTH): entry index width
- TAG_W, IDX_W+1: tag width; tag = {free_bit, idx}; free_bit = 1 means "no dependency"

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- alloc_valid  in  1  dispatch requests an entry
- alloc_rd  in  5  destination register; 0 = no writeback
- alloc_is_branch  in  1  entry is a branch
- alloc_ready  out  1  entry available this cycle
- alloc_tag  out  TAG_W  {1'b0, tail}; the tag assigned if the request is accepted
- q1_tag, q2_tag  in  TAG_W  operand tags to resolve
- q1_ready, q2_ready  out  1  operand value available
- q1_data, q2_data  out  XLEN  operand value
- cdb_valid  in  NCDB  per-channel broadcast strobe
- cdb_tag  in  NCDB*TAG_W  packed tags; channel k occupies bits [k*TAG_W +: TAG_W]
- cdb_data  in  NCDB*XLEN  packed results; for a branch this is the correct next PC
- cdb_mispredict  in  NCDB  the branch result on this channel mispredicted
- commit_valid  out  1  head entry retires this cycle
- commit_rd  out  5  register written by the retiring entry
- commit_data  out  XLEN  value written by the retiring entry
- commit_tag  out  TAG_W  tag of the retiring entry; the register file clears a matching busy tag
- flush  out  1  a mispredicted branch retires this cycle
- redirect_pc  out  XLEN  fetch target, valid when flush = 1
- count  out  IDX_W+1  occupied entries

## Operation
- Each entry holds: busy, ready, is_branch, mispredict, rd, data.
- Pointers: head and tail are IDX_W bits and wrap modulo DEPTH. count ranges 0..DEPTH.
- Allocate:
  - alloc_ready = (count != DEPTH) && !flush.
  - When alloc_valid && alloc_ready, the entry at tail is written with busy=1, ready=0, and tail increments.
  - When alloc_valid is asserted without alloc_ready, the request is ignored; dispatch holds it.
- CDB capture: for each k with cdb_valid[k], tag free_bit=0 and the target entry busy:
  - data ← cdb_data[k], ready ← 1, mispredict ← cdb_mispredict[k].
  - Broadcasts to non-busy entries or free tags are ignored.
  - Two channels targeting the same tag in one cycle is a protocol violation; the lowest k wins.
- Commit is combinational from the head entry:
  - commit_valid = (count != 0) && head.ready.
  - commit_rd = is_branch ? 0 : rd.
  - commit_data = head.data; commit_tag = {1'b0, head}.
- On the commit edge: the head entry's busy is cleared and head increments.
- flush = commit_valid && head.is_branch && head.mispredict; redirect_pc = head.data.
- On the flush edge:
  - all busy bits clear; head = tail = 0, count = 0.
  - CDB writes in that cycle are discarded.
  - the committing entry itself is still reported on commit_* that cycle.
- Operand lookup, per port:
  - tag free_bit=1 → ready=1, data=0 (value comes from the register file).
  - entry ready → ready=1, data=entry.data.
  - otherwise → ready=0, data=0.
- count next = count + accept − retire; simultaneous alloc and commit leaves count unchanged.

## Timing
- Reset values:
  - alloc_ready=1, alloc_tag=0, count=0.
  - commit_valid=0, commit_rd=0, commit_data=0, commit_tag=0.
  - flush=0, redirect_pc=0.
  - all entries not busy.
- rst asserted mid-operation drops all in-flight entries at the next edge, exactly like a flush but without flush or redirect.
- Allocation to earliest commit is 2 cycles: allocate at edge N, CDB write at edge N+1, commit_valid high in cycle N+1, retire at edge N+2.
- A CDB write becomes visible to commit and to lookup (non-bypass) one cycle after the broadcast.
- Full boundary: when count=DEPTH, alloc_ready=0 even if a retire happens the same cycle; the freed slot is usable the following cycle.
- Wrap-around: tail and head index DEPTH−1 followed by 0; tags are reused after retirement.

## Configuration
- ROB_CDB_BYPASS_EN defined: operand lookup also compares q*_tag against every valid CDB channel in the current cycle. On a match, ready=1 and data=cdb_data (lowest k first), so an operand resolves in the broadcast cycle.
- Undefined: lookup reads stored entries only, so an operand resolves the cycle after its broadcast.

## Test plan
- Reset, then allocate 3 (rd=1,2,3); CDB writes tag1=0x22 and tag0=0x11 in one cycle on channels 0 and 1 → commits rd1=0x11 then rd2=0x22 on consecutive cycles; rd3 holds.
- Fill all 16 entries → alloc_ready=0, count=16. Commit 1 + alloc in the same cycle → alloc rejected; next cycle accepted with tag 0x00 (wrap).
- A branch at the head with cdb_mispredict=1 and data=0x400, plus 4 younger entries → flush=1, redirect_pc=0x400 in one cycle; next cycle count=0, alloc_tag=0.
- q1_tag=tag5 while channel 2 broadcasts tag5=0xABCD → q1_ready=1, q1_data=0xABCD in the same cycle with ROB_CDB_BYPASS_EN; without it, the same values appear the next cycle.
- q2_tag free (MSB=1) → q2_ready=1, q2_data=0. A CDB broadcast to a non-busy entry → no state change.
- Assert rst with 5 busy entries → next cycle count=0, commit_valid=0, flush=0.
